// File: rtl/araddr_fifo_arbiter.sv
// Round-robin arbiter draining per-channel read-address prefetch FIFOs into one AXI AR channel,
// with per-channel outstanding-burst credits retired by R-channel last beats and a drain mode.
module araddr_fifo_arbiter #(
   parameter int N_CH      = 4,
   parameter int ADDR_W    = 28,
   parameter int LEN_W     = 8,
   parameter int ID_W      = 3,
   parameter int MAX_OUTST = 4
) (
   input  logic                             rd_clk,
   input  logic                             rd_rst,
   input  logic                             arb_en,
   input  logic [N_CH-1:0]                  ch_vld,
   input  logic [N_CH*(LEN_W+ADDR_W)-1:0]   ch_data,
   output logic [N_CH-1:0]                  ch_rd_en,
   output logic                             m_arvalid,
   input  logic                             m_arready,
   output logic [ADDR_W-1:0]                m_araddr,
   output logic [LEN_W-1:0]                 m_arlen,
   output logic [ID_W-1:0]                  m_arid,
   input  logic                             m_rvalid,
   input  logic                             m_rready,
   input  logic                             m_rlast,
   input  logic [ID_W-1:0]                  m_rid,
   output logic                             idle,
   output logic                             err_rid
);

   localparam int DW = LEN_W + ADDR_W;
   localparam int CW = $clog2(MAX_OUTST + 1);
   localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_STOPPED = 2'd2
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg [N_CH];
   logic [GW-1:0]   last_grant_reg;

   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] inc;
   logic [N_CH-1:0] dec;
   logic [N_CH-1:0] elig;
   logic [N_CH-1:0] cnt_zero;
   logic [N_CH-1:0] dec_underflow;
   logic [GW-1:0]   grant;
   logic            grant_vld;
   logic            can_load;
   logic            pop;
   logic            run;
   logic            r_last_hs;
   logic            rid_bad;
   logic [DW-1:0]   grant_data;

   assign run       = (state_reg == ST_RUN);
   assign can_load  = ~m_arvalid | m_arready;
   assign pop       = grant_vld & can_load;
   assign r_last_hs = m_rvalid & m_rready & m_rlast;
   assign rid_bad   = ({1'b0, m_rid} >= (ID_W+1)'(N_CH));
   assign grant_data = ch_data[int'(grant)*DW +: DW];
   assign idle      = ~m_arvalid & (&cnt_zero);

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         // A beat sitting in the AR register is not yet counted, so it consumes a credit
         // whether or not it is being accepted this cycle; otherwise back-to-back issue overshoots.
         assign pend[gi]     = m_arvalid & (m_arid == ID_W'(gi));
         assign inc[gi]      = m_arvalid & m_arready & (m_arid == ID_W'(gi));
         assign dec[gi]      = r_last_hs & (m_rid == ID_W'(gi));
         assign cnt_zero[gi] = (cnt_reg[gi] == '0);
         assign elig[gi]     = ch_vld[gi] & arb_en & run &
                               (({1'b0, cnt_reg[gi]} + (CW+1)'(pend[gi])) < (CW+1)'(MAX_OUTST));
         assign dec_underflow[gi] = dec[gi] & ~inc[gi] & cnt_zero[gi];
         assign ch_rd_en[gi] = pop & (grant == GW'(gi));

         always_ff @(posedge rd_clk or posedge rd_rst) begin
            if (rd_rst) begin
               cnt_reg[gi] <= '0;
            end else if (inc[gi] & ~dec[gi]) begin
               cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end else if (dec[gi] & ~inc[gi] & ~cnt_zero[gi]) begin
               cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
            end
         end
      end
   endgenerate

   // Rotating-priority scan starting just after the last granted channel.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         if (!grant_vld && elig[GW'((int'(last_grant_reg) + k) % N_CH)]) begin
            grant     = GW'((int'(last_grant_reg) + k) % N_CH);
            grant_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         m_arvalid      <= 1'b0;
         m_araddr       <= '0;
         m_arlen        <= '0;
         m_arid         <= '0;
         last_grant_reg <= GW'(N_CH - 1);
      end else if (pop) begin
         m_arvalid      <= 1'b1;
         m_araddr       <= grant_data[ADDR_W-1:0];
         m_arlen        <= grant_data[DW-1:ADDR_W];
         m_arid         <= ID_W'(grant);
         last_grant_reg <= grant;
      end else if (m_arready) begin
         m_arvalid      <= 1'b0;
      end
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         err_rid <= 1'b0;
      end else if ((r_last_hs & rid_bad) | (|dec_underflow)) begin
         err_rid <= 1'b1;
      end
   end

   // DRAIN ignores arb_en until every burst has retired, so resume is always from a clean state.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_reg <= ST_RUN;
      end else begin
         case (state_reg)
            ST_RUN:     if (!arb_en) state_reg <= ST_DRAIN;
            ST_DRAIN:   if (!m_arvalid && (&cnt_zero)) state_reg <= ST_STOPPED;
            ST_STOPPED: if (arb_en) state_reg <= ST_RUN;
            default:    state_reg <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_araddr_fifo_arbiter.sv
// Directed bench for araddr_fifo_arbiter: grant order, credits, backpressure, drain and error flag.
module tb_araddr_fifo_arbiter;

   localparam int N_CH = 4, ADDR_W = 28, LEN_W = 8, ID_W = 3, MAX_OUTST = 4;
   localparam int DW = LEN_W + ADDR_W;

   logic                   rd_clk = 1'b0;
   logic                   rd_rst;
   logic                   arb_en;
   logic [N_CH-1:0]        ch_vld;
   logic [N_CH*DW-1:0]     ch_data;
   logic [N_CH-1:0]        ch_rd_en;
   logic                   m_arvalid;
   logic                   m_arready;
   logic [ADDR_W-1:0]      m_araddr;
   logic [LEN_W-1:0]       m_arlen;
   logic [ID_W-1:0]        m_arid;
   logic                   m_rvalid, m_rready, m_rlast;
   logic [ID_W-1:0]        m_rid;
   logic                   idle;
   logic                   err_rid;

   int tests = 0;
   int fails = 0;

   araddr_fifo_arbiter #(
      .N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
   ) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .arb_en(arb_en), .ch_vld(ch_vld), .ch_data(ch_data),
      .ch_rd_en(ch_rd_en), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_rlast(m_rlast), .m_rid(m_rid), .idle(idle), .err_rid(err_rid)
   );

   always #5 rd_clk = ~rd_clk;

   task automatic tick;
      @(posedge rd_clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
      ch_data[i*DW +: DW] = {len, addr};
   endtask

   task automatic r_beat(input logic en, input logic [ID_W-1:0] id);
      m_rvalid = en;
      m_rready = en;
      m_rlast  = en;
      m_rid    = id;
   endtask

   task automatic do_reset;
      rd_rst    = 1'b1;
      arb_en    = 1'b1;
      ch_vld    = '0;
      ch_data   = '0;
      m_arready = 1'b0;
      r_beat(1'b0, '0);
      tick;
      tick;
      rd_rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      #1;
      tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL rst_arvalid got=%b exp=0", m_arvalid); end
      tests++; if (m_araddr !== '0 || m_arlen !== '0 || m_arid !== '0) begin
         fails++; $display("FAIL rst_beat got addr=%h len=%h id=%0d exp=0", m_araddr, m_arlen, m_arid); end
      tests++; if (ch_rd_en !== 4'b0000) begin fails++; $display("FAIL rst_rd_en got=%b exp=0000", ch_rd_en); end
      tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rst_idle got=%b exp=1", idle); end
      tests++; if (err_rid !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", err_rid); end
      tests++; if (int'(dut.state_reg) !== 0) begin fails++; $display("FAIL rst_state got=%0d exp=0", int'(dut.state_reg)); end
      for (int i = 0; i < N_CH; i++) begin
         tests++; if (dut.cnt_reg[i] !== '0) begin fails++; $display("FAIL rst_cnt%0d got=%0d exp=0", i, dut.cnt_reg[i]); end
      end
   endtask

   task automatic test_single;
      do_reset;
      set_ch(0, 8'h0F, 28'h0001000);
      ch_vld    = 4'b0001;
      m_arready = 1'b1;
      #1;
      tests++; if (ch_rd_en !== 4'b0001) begin fails++; $display("FAIL single_pop got=%b exp=0001", ch_rd_en); end
      tick;
      ch_vld = 4'b0000;
      #1;
      $display("[TB] single AR id=%0d addr=%h len=%0d", m_arid, m_araddr, m_arlen);
      tests++; if (m_arvalid !== 1'b1 || m_araddr !== 28'h0001000 || m_arlen !== 8'h0F || m_arid !== 3'd0) begin
         fails++; $display("FAIL single_beat got v=%b addr=%h len=%h id=%0d exp v=1 addr=0001000 len=0f id=0",
                           m_arvalid, m_araddr, m_arlen, m_arid); end
      tests++; if (ch_rd_en !== 4'b0000) begin fails++; $display("FAIL single_nopop got=%b exp=0000", ch_rd_en); end
      tick;
      tests++; if (dut.cnt_reg[0] !== 3'd1) begin fails++; $display("FAIL single_cnt got=%0d exp=1", dut.cnt_reg[0]); end
      tests++; if (idle !== 1'b0) begin fails++; $display("FAIL single_idle got=%b exp=0", idle); end
      tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL single_empty got=%b exp=0", m_arvalid); end
   endtask

   task automatic test_round_robin;
      logic [ADDR_W-1:0] exp_addr;
      do_reset;
      for (int i = 0; i < N_CH; i++) set_ch(i, 8'(i + 1), 28'h0100000 + 28'(i * 'h100));
      ch_vld    = 4'b1111;
      m_arready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         tests++; if (ch_rd_en !== 4'(1 << (k % 4))) begin
            fails++; $display("FAIL rr_pop%0d got=%b exp=%b", k, ch_rd_en, 4'(1 << (k % 4))); end
         tick;
         exp_addr = 28'h0100000 + 28'((k % 4) * 'h100);
         $display("[TB] rr AR id=%0d addr=%h len=%0d", m_arid, m_araddr, m_arlen);
         tests++; if (m_arvalid !== 1'b1 || m_arid !== 3'(k % 4) || m_araddr !== exp_addr) begin
            fails++; $display("FAIL rr_beat%0d got v=%b id=%0d addr=%h exp v=1 id=%0d addr=%h",
                              k, m_arvalid, m_arid, m_araddr, k % 4, exp_addr); end
      end
      ch_vld = 4'b0000;
      tick;
      for (int i = 0; i < N_CH; i++) begin
         tests++; if (dut.cnt_reg[i] !== 3'd2) begin fails++; $display("FAIL rr_cnt%0d got=%0d exp=2", i, dut.cnt_reg[i]); end
      end
   endtask

   task automatic test_credit;
      int pops;
      pops = 0;
      do_reset;
      set_ch(0, 8'h01, 28'h0200000);
      ch_vld    = 4'b0001;
      m_arready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (ch_rd_en[0]) pops++;
         tick;
      end
      tests++; if (pops !== MAX_OUTST) begin fails++; $display("FAIL credit_pops got=%0d exp=%0d", pops, MAX_OUTST); end
      tests++; if (dut.cnt_reg[0] !== 3'd4) begin fails++; $display("FAIL credit_cnt got=%0d exp=4", dut.cnt_reg[0]); end
      tests++; if (ch_rd_en !== 4'b0000 || m_arvalid !== 1'b0) begin
         fails++; $display("FAIL credit_masked got rd_en=%b v=%b exp 0000/0", ch_rd_en, m_arvalid); end
      r_beat(1'b1, 3'd0);
      #1;
      tests++; if (ch_rd_en !== 4'b0000) begin fails++; $display("FAIL credit_same_cyc got=%b exp=0000", ch_rd_en); end
      tick;
      r_beat(1'b0, 3'd0);
      #1;
      tests++; if (ch_rd_en !== 4'b0001) begin fails++; $display("FAIL credit_freed got=%b exp=0001", ch_rd_en); end
      tick;
      $display("[TB] credit AR id=%0d addr=%h len=%0d", m_arid, m_araddr, m_arlen);
      tests++; if (m_arvalid !== 1'b1 || m_arid !== 3'd0) begin
         fails++; $display("FAIL credit_fifth got v=%b id=%0d exp v=1 id=0", m_arvalid, m_arid); end
      ch_vld = 4'b0000;
      tick;
      tests++; if (dut.cnt_reg[0] !== 3'd4) begin fails++; $display("FAIL credit_cnt2 got=%0d exp=4", dut.cnt_reg[0]); end
   endtask

   task automatic test_backpressure;
      do_reset;
      set_ch(0, 8'h03, 28'h0AAAAAA);
      set_ch(1, 8'h07, 28'h0BBBBBB);
      ch_vld    = 4'b0011;
      m_arready = 1'b0;
      #1;
      tests++; if (ch_rd_en !== 4'b0001) begin fails++; $display("FAIL bp_pop got=%b exp=0001", ch_rd_en); end
      tick;
      set_ch(0, 8'hFF, 28'h0CCCCCC);
      for (int k = 0; k < 10; k++) begin
         #1;
         tests++; if (ch_rd_en !== 4'b0000 || m_arvalid !== 1'b1 || m_araddr !== 28'h0AAAAAA ||
                      m_arlen !== 8'h03 || m_arid !== 3'd0) begin
            fails++; $display("FAIL bp_hold%0d got rd_en=%b v=%b addr=%h len=%h id=%0d exp 0000/1/0aaaaaa/03/0",
                              k, ch_rd_en, m_arvalid, m_araddr, m_arlen, m_arid); end
         tick;
      end
      m_arready = 1'b1;
      #1;
      tests++; if (ch_rd_en !== 4'b0010) begin fails++; $display("FAIL bp_release got=%b exp=0010", ch_rd_en); end
      tick;
      $display("[TB] bp AR id=%0d addr=%h len=%0d", m_arid, m_araddr, m_arlen);
      tests++; if (m_arvalid !== 1'b1 || m_arid !== 3'd1 || m_araddr !== 28'h0BBBBBB) begin
         fails++; $display("FAIL bp_next got v=%b id=%0d addr=%h exp v=1 id=1 addr=0bbbbbb", m_arvalid, m_arid, m_araddr); end
      tests++; if (dut.cnt_reg[0] !== 3'd1) begin fails++; $display("FAIL bp_cnt0 got=%0d exp=1", dut.cnt_reg[0]); end
      ch_vld = 4'b0000;
      tick;
   endtask

   task automatic test_drain;
      do_reset;
      for (int i = 0; i < N_CH; i++) set_ch(i, 8'h10, 28'h0300000 + 28'(i * 'h40));
      ch_vld    = 4'b0111;
      m_arready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests++; if (ch_rd_en !== 4'(1 << k)) begin fails++; $display("FAIL drain_fill%0d got=%b exp=%b", k, ch_rd_en, 4'(1 << k)); end
         tick;
      end
      arb_en = 1'b0;
      ch_vld = 4'b1111;
      #1;
      tests++; if (ch_rd_en !== 4'b0000) begin fails++; $display("FAIL drain_suppress got=%b exp=0000", ch_rd_en); end
      tick;
      tests++; if (int'(dut.state_reg) !== 1 || idle !== 1'b0) begin
         fails++; $display("FAIL drain_enter got state=%0d idle=%b exp state=1 idle=0", int'(dut.state_reg), idle); end
      for (int j = 0; j < 3; j++) begin
         r_beat(1'b1, 3'(j));
         #1;
         tests++; if (ch_rd_en !== 4'b0000) begin fails++; $display("FAIL drain_nopop%0d got=%b exp=0000", j, ch_rd_en); end
         tick;
      end
      r_beat(1'b0, 3'd0);
      tests++; if (idle !== 1'b1) begin fails++; $display("FAIL drain_idle got=%b exp=1", idle); end
      tick;
      tests++; if (int'(dut.state_reg) !== 2 || idle !== 1'b1) begin
         fails++; $display("FAIL drain_stopped got state=%0d idle=%b exp state=2 idle=1", int'(dut.state_reg), idle); end
      arb_en = 1'b1;
      #1;
      tests++; if (ch_rd_en !== 4'b0000) begin fails++; $display("FAIL drain_stop_nopop got=%b exp=0000", ch_rd_en); end
      tick;
      tests++; if (ch_rd_en !== 4'b1000) begin fails++; $display("FAIL drain_resume got=%b exp=1000", ch_rd_en); end
      tick;
      $display("[TB] drain AR id=%0d addr=%h len=%0d", m_arid, m_araddr, m_arlen);
      tests++; if (m_arvalid !== 1'b1 || m_arid !== 3'd3) begin
         fails++; $display("FAIL drain_resume_id got v=%b id=%0d exp v=1 id=3", m_arvalid, m_arid); end
      ch_vld = 4'b0000;
      tick;
   endtask

   task automatic test_simul_err;
      do_reset;
      set_ch(2, 8'h05, 28'h0400000);
      ch_vld    = 4'b0100;
      m_arready = 1'b1;
      tick;
      ch_vld = 4'b0000;
      tick;
      tests++; if (dut.cnt_reg[2] !== 3'd1) begin fails++; $display("FAIL sim_cnt_pre got=%0d exp=1", dut.cnt_reg[2]); end
      ch_vld = 4'b0100;
      tick;
      ch_vld = 4'b0000;
      r_beat(1'b1, 3'd2);
      tick;
      r_beat(1'b0, 3'd0);
      tests++; if (dut.cnt_reg[2] !== 3'd1 || err_rid !== 1'b0) begin
         fails++; $display("FAIL sim_same_cyc got cnt=%0d err=%b exp cnt=1 err=0", dut.cnt_reg[2], err_rid); end
      r_beat(1'b1, 3'd5);
      tick;
      r_beat(1'b0, 3'd0);
      tests++; if (err_rid !== 1'b1) begin fails++; $display("FAIL err_badrid got=%b exp=1", err_rid); end
      tick; tick; tick;
      tests++; if (err_rid !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", err_rid); end
      ch_vld    = 4'b0100;
      m_arready = 1'b0;
      tick;
      ch_vld = 4'b0000;
      #2;
      rd_rst = 1'b1;
      #1;
      tests++; if (m_arvalid !== 1'b0 || err_rid !== 1'b0 || dut.cnt_reg[2] !== 3'd0) begin
         fails++; $display("FAIL async_rst got v=%b err=%b cnt2=%0d exp 0/0/0", m_arvalid, err_rid, dut.cnt_reg[2]); end
      tick;
      rd_rst = 1'b0;
      r_beat(1'b1, 3'd1);
      tick;
      r_beat(1'b0, 3'd0);
      tests++; if (err_rid !== 1'b1 || dut.cnt_reg[1] !== 3'd0) begin
         fails++; $display("FAIL err_underflow got err=%b cnt1=%0d exp err=1 cnt1=0", err_rid, dut.cnt_reg[1]); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_round_robin;
      test_credit;
      test_backpressure;
      test_drain;
      test_simul_err;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
